// File: rtl/uart_cmd_arb.sv
// -----------------------------------------------------------------------------
// uart_cmd_arb
//
// Round-robin arbiter that shares one uart command port among NREQ client
// blocks and routes each uart read return back to the client that issued
// the read. Exactly one command is in flight at a time.
//
// Parameters
//   NREQ        number of requesters (2..4)
//   RD_TIMEOUT  WAIT_RD cycles before a read is aborted (timeout build only)
//
// Optional feature
//   UART_ARB_TIMEOUT_EN  when defined, a read that gets no read_rdy within
//                        RD_TIMEOUT cycles is aborted and answered with
//                        resp_err = 1, resp_data = 8'hFF. When undefined,
//                        WAIT_RD waits indefinitely and resp_err is 0.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   req_cmd/vld     per-requester 16-bit command (slice i = [16*i+15:16*i])
//   req_rdy         combinational accept pulse to the granted requester
//   resp_data/vld   read return data and one-hot owner pulse
//   resp_err        read aborted by timeout (qualified by resp_vld)
//   busy            arbiter not in IDLE
//   cmd_in/vld/rdy  command handshake towards the uart
//   read_rdy/data   read return from the uart (single-cycle pulse)
// -----------------------------------------------------------------------------
module uart_cmd_arb #(
   parameter int NREQ       = 2,
   parameter int RD_TIMEOUT = 50000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ*16-1:0]   req_cmd,
   input  logic [NREQ-1:0]      req_vld,
   output logic [NREQ-1:0]      req_rdy,
   output logic [7:0]           resp_data,
   output logic [NREQ-1:0]      resp_vld,
   output logic                 resp_err,
   output logic                 busy,
   output logic [15:0]          cmd_in,
   output logic                 cmd_vld,
   input  logic                 cmd_rdy,
   input  logic                 read_rdy,
   input  logic [7:0]           read_data
);

   localparam int GW = (NREQ > 2) ? 2 : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [15:0]     cmd_in_q, cmd_in_d;
   logic            cmd_vld_q, cmd_vld_d;
   logic [NREQ-1:0] resp_vld_q, resp_vld_d;
   logic [7:0]      resp_data_q, resp_data_d;

`ifdef UART_ARB_TIMEOUT_EN
   logic            resp_err_q, resp_err_d;
   logic [15:0]     tmo_cnt_q, tmo_cnt_d;
`endif

   // Unpack the flat command bus into one word per requester.
   logic [15:0] cmd_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign cmd_arr[gi] = req_cmd[16*gi+15 : 16*gi];
      end
   endgenerate

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   logic          found;
   logic [GW-1:0] gsel;
   logic [GW-1:0] idx;

   always_comb begin
      found = 1'b0;
      gsel  = '0;
      idx   = rr_ptr_q;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_vld[idx]) begin
            found = 1'b1;
            gsel  = idx;
         end
         idx = (idx == GW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
   end

   // The accept pulse is combinational so the command transfers in the same
   // cycle as the grant; it is masked during reset so a held request is not
   // acknowledged while the arbiter is being cleared.
   always_comb begin
      req_rdy = '0;
      if (rst_n && (state_q == IDLE) && found) begin
         req_rdy[gsel] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      cmd_in_d    = cmd_in_q;
      cmd_vld_d   = cmd_vld_q;
      resp_vld_d  = '0;
      resp_data_d = resp_data_q;
`ifdef UART_ARB_TIMEOUT_EN
      resp_err_d  = resp_err_q;
      tmo_cnt_d   = tmo_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               cmd_in_d  = cmd_arr[gsel];
               cmd_vld_d = 1'b1;
               grant_d   = gsel;
               rr_ptr_d  = (gsel == GW'(NREQ - 1)) ? '0 : gsel + 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_rdy) begin
               cmd_vld_d = 1'b0;
               // Only reads (bit 15 set) expect a return from the uart.
               state_d   = cmd_in_q[15] ? WAIT_RD : IDLE;
`ifdef UART_ARB_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         WAIT_RD: begin
            if (read_rdy) begin
               resp_data_d         = read_data;
               resp_vld_d[grant_q] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
               resp_err_d          = 1'b0;
`endif
               state_d             = IDLE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (tmo_cnt_q == 16'(RD_TIMEOUT - 1)) begin
               resp_data_d         = 8'hFF;
               resp_vld_d[grant_q] = 1'b1;
               resp_err_d          = 1'b1;
               state_d             = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
`endif
         end
         default: begin
            state_d   = IDLE;
            cmd_vld_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         cmd_in_q    <= '0;
         cmd_vld_q   <= 1'b0;
         resp_vld_q  <= '0;
         resp_data_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         resp_err_q  <= 1'b0;
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         cmd_in_q    <= cmd_in_d;
         cmd_vld_q   <= cmd_vld_d;
         resp_vld_q  <= resp_vld_d;
         resp_data_q <= resp_data_d;
`ifdef UART_ARB_TIMEOUT_EN
         resp_err_q  <= resp_err_d;
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign cmd_in    = cmd_in_q;
   assign cmd_vld   = cmd_vld_q;
   assign resp_vld  = resp_vld_q;
   assign resp_data = resp_data_q;
   assign busy      = (state_q != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
   assign resp_err  = resp_err_q;
`else
   assign resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_arb
//
// Directed bench for uart_cmd_arb (NREQ = 2, RD_TIMEOUT = 8). A table of
// per-cycle input/expected-output records covers reset, writes, backpressure,
// read routing, spurious read_rdy and mid-operation reset; hand-written
// sequences cover fairness and the read timeout (UART_ARB_TIMEOUT_EN).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_cmd_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] req_cmd;
   logic [1:0]  req_vld;
   logic [1:0]  req_rdy;
   logic [7:0]  resp_data;
   logic [1:0]  resp_vld;
   logic        resp_err;
   logic        busy;
   logic [15:0] cmd_in;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        read_rdy;
   logic [7:0]  read_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_cmd_arb #(
      .NREQ       (2),
      .RD_TIMEOUT (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_cmd   (req_cmd),
      .req_vld   (req_vld),
      .req_rdy   (req_rdy),
      .resp_data (resp_data),
      .resp_vld  (resp_vld),
      .resp_err  (resp_err),
      .busy      (busy),
      .cmd_in    (cmd_in),
      .cmd_vld   (cmd_vld),
      .cmd_rdy   (cmd_rdy),
      .read_rdy  (read_rdy),
      .read_data (read_data)
   );

   typedef struct {
      logic        rst_n;
      logic [1:0]  vld;
      logic [15:0] c0;
      logic [15:0] c1;
      logic        crdy;
      logic        rrdy;
      logic [7:0]  rdata;
      logic [1:0]  e_req_rdy;
      logic        e_cmd_vld;
      logic        ck_cmd_in;
      logic [15:0] e_cmd_in;
      logic [1:0]  e_resp_vld;
      logic [7:0]  e_resp_data;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [1:0] v, input logic [15:0] c0,
                      input logic [15:0] c1, input logic cr, input logic rr,
                      input logic [7:0] rd, input logic [1:0] e_rq,
                      input logic e_cv, input logic ck, input logic [15:0] e_ci,
                      input logic [1:0] e_rv, input logic [7:0] e_rd,
                      input logic e_b);
      vec_t t;
      t.rst_n = r; t.vld = v; t.c0 = c0; t.c1 = c1; t.crdy = cr;
      t.rrdy = rr; t.rdata = rd; t.e_req_rdy = e_rq; t.e_cmd_vld = e_cv;
      t.ck_cmd_in = ck; t.e_cmd_in = e_ci; t.e_resp_vld = e_rv;
      t.e_resp_data = e_rd; t.e_busy = e_b;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] v, input logic [15:0] c0,
                        input logic [15:0] c1, input logic cr, input logic rr,
                        input logic [7:0] rd);
      rst_n     = r;
      req_vld   = v;
      req_cmd   = {c1, c0};
      cmd_rdy   = cr;
      read_rdy  = rr;
      read_data = rd;
   endtask

   // Finish the current cycle and land 1 unit after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rst  vld    c0        c1        crdy rrdy rdata | req_rdy cvld ck cmd_in    resp_vld rdata busy
      add(0, 2'b11, 16'h000A, 16'h0BBB, 1, 0, 8'h00,  2'b00, 0, 1, 16'h0000, 2'b00, 8'h00, 0); // 0 reset
      add(1, 2'b11, 16'h000A, 16'h0BBB, 1, 0, 8'h00,  2'b01, 0, 0, 16'h0000, 2'b00, 8'h00, 0); // 1 first grant -> 0
      add(1, 2'b00, 16'h000A, 16'h0BBB, 1, 0, 8'h00,  2'b00, 1, 1, 16'h000A, 2'b00, 8'h00, 1); // 2 write out
      add(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 8'h00,  2'b00, 0, 0, 16'h0000, 2'b00, 8'h00, 0); // 3 idle again
      add(1, 2'b10, 16'h0044, 16'h0033, 0, 0, 8'h00,  2'b10, 0, 0, 16'h0000, 2'b00, 8'h00, 0); // 4 grant 1
      for (int i = 0; i < 5; i++)                                                                 // 5-9 stall
         add(1, 2'b01, 16'h0044, 16'h0033, 0, 0, 8'h00, 2'b00, 1, 1, 16'h0033, 2'b00, 8'h00, 1);
      add(1, 2'b01, 16'h0044, 16'h0033, 1, 0, 8'h00,  2'b00, 1, 1, 16'h0033, 2'b00, 8'h00, 1); // 10 transfer
      add(1, 2'b01, 16'h0044, 16'h0033, 1, 0, 8'h00,  2'b01, 0, 0, 16'h0000, 2'b00, 8'h00, 0); // 11 grant 0
      add(1, 2'b00, 16'h0044, 16'h0000, 1, 0, 8'h00,  2'b00, 1, 1, 16'h0044, 2'b00, 8'h00, 1); // 12
      add(1, 2'b10, 16'h0000, 16'h8012, 1, 0, 8'h00,  2'b10, 0, 0, 16'h0000, 2'b00, 8'h00, 0); // 13 read by 1
      add(1, 2'b00, 16'h0000, 16'h8012, 1, 0, 8'h00,  2'b00, 1, 1, 16'h8012, 2'b00, 8'h00, 1); // 14 transfer
      add(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 8'h00,  2'b00, 0, 0, 16'h0000, 2'b00, 8'h00, 1); // 15 wait
      add(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 8'h00,  2'b00, 0, 0, 16'h0000, 2'b00, 8'h00, 1); // 16 wait
      add(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 8'h5C,  2'b00, 0, 0, 16'h0000, 2'b00, 8'h00, 1); // 17 read_rdy
      add(1, 2'b01, 16'h0055, 16'h0000, 1, 1, 8'h77,  2'b01, 0, 0, 16'h0000, 2'b10, 8'h5C, 0); // 18 resp + grant
      add(1, 2'b00, 16'h0055, 16'h0000, 0, 1, 8'h66,  2'b00, 1, 1, 16'h0055, 2'b00, 8'h5C, 1); // 19 spurious
      add(1, 2'b00, 16'h0055, 16'h0000, 1, 0, 8'h00,  2'b00, 1, 1, 16'h0055, 2'b00, 8'h5C, 1); // 20
      add(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 8'h99,  2'b00, 0, 0, 16'h0000, 2'b00, 8'h5C, 0); // 21 spurious
      add(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 8'h00,  2'b00, 0, 0, 16'h0000, 2'b00, 8'h5C, 0); // 22
      add(1, 2'b01, 16'h80A5, 16'h0000, 1, 0, 8'h00,  2'b01, 0, 0, 16'h0000, 2'b00, 8'h5C, 0); // 23 read by 0
      add(1, 2'b00, 16'h80A5, 16'h0000, 1, 0, 8'h00,  2'b00, 1, 1, 16'h80A5, 2'b00, 8'h5C, 1); // 24
      add(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 8'hC3,  2'b00, 0, 0, 16'h0000, 2'b00, 8'h5C, 1); // 25 read_rdy
      add(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 8'h00,  2'b00, 0, 0, 16'h0000, 2'b01, 8'hC3, 0); // 26 resp to 0
      add(1, 2'b10, 16'h0000, 16'h8001, 1, 0, 8'h00,  2'b10, 0, 0, 16'h0000, 2'b00, 8'hC3, 0); // 27 read by 1
      add(1, 2'b00, 16'h0000, 16'h8001, 1, 0, 8'h00,  2'b00, 1, 1, 16'h8001, 2'b00, 8'hC3, 1); // 28
      add(0, 2'b00, 16'h0000, 16'h0000, 0, 0, 8'h00,  2'b00, 0, 0, 16'h0000, 2'b00, 8'hC3, 1); // 29 reset mid-read
      add(1, 2'b00, 16'h0000, 16'h0000, 0, 1, 8'h11,  2'b00, 0, 1, 16'h0000, 2'b00, 8'h00, 0); // 30 cleared
      add(1, 2'b11, 16'h0001, 16'h0002, 1, 0, 8'h00,  2'b01, 0, 0, 16'h0000, 2'b00, 8'h00, 0); // 31 rr back to 0
      add(1, 2'b00, 16'h0001, 16'h0002, 1, 0, 8'h00,  2'b00, 1, 1, 16'h0001, 2'b00, 8'h00, 1); // 32
      add(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 8'h00,  2'b00, 0, 0, 16'h0000, 2'b00, 8'h00, 0); // 33

      // Two reset edges with both requesters asserting.
      drive(0, 2'b11, 16'h000A, 16'h0BBB, 1, 0, 8'h00);
      next_cycle();
      next_cycle();

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].vld, vecs[i].c0, vecs[i].c1,
               vecs[i].crdy, vecs[i].rrdy, vecs[i].rdata);
         @(negedge clk);
         chk($sformatf("row%0d req_rdy", i), 32'(req_rdy), 32'(vecs[i].e_req_rdy));
         chk($sformatf("row%0d cmd_vld", i), 32'(cmd_vld), 32'(vecs[i].e_cmd_vld));
         if (vecs[i].ck_cmd_in)
            chk($sformatf("row%0d cmd_in", i), 32'(cmd_in), 32'(vecs[i].e_cmd_in));
         chk($sformatf("row%0d resp_vld", i), 32'(resp_vld), 32'(vecs[i].e_resp_vld));
         chk($sformatf("row%0d resp_data", i), 32'(resp_data), 32'(vecs[i].e_resp_data));
         chk($sformatf("row%0d resp_err", i), 32'(resp_err), 32'd0);
         chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
         $display("row %0d: req_rdy=%b cmd_vld=%b cmd_in=%h resp_vld=%b resp_data=%h busy=%b",
                  i, req_rdy, cmd_vld, cmd_in, resp_vld, resp_data, busy);
         next_cycle();
      end

      // Fairness: both requesters hold writes, grants must alternate 0,1,0,1.
      drive(0, 2'b11, 16'h0100, 16'h0201, 1, 0, 8'h00);
      next_cycle();
      next_cycle();
      begin
         logic [1:0] onehot_exp;
         int         exp_g;
         exp_g = 0;
         for (int n = 0; n < 8; n++) begin
            onehot_exp = (exp_g == 0) ? 2'b01 : 2'b10;
            drive(1, 2'b11, 16'h0100, 16'h0201, 1, 0, 8'h00);
            @(negedge clk);
            chk($sformatf("fair%0d req_rdy", n), 32'(req_rdy), 32'(onehot_exp));
            next_cycle();
            @(negedge clk);
            chk($sformatf("fair%0d cmd_vld", n), 32'(cmd_vld), 32'd1);
            chk($sformatf("fair%0d cmd_in", n), 32'(cmd_in),
                (exp_g == 0) ? 32'h0100 : 32'h0201);
            chk($sformatf("fair%0d no_rdy", n), 32'(req_rdy), 32'd0);
            $display("fair %0d: granted cmd_in=%h", n, cmd_in);
            next_cycle();
            exp_g = 1 - exp_g;
         end
      end

      // Read from requester 0 that never gets read_rdy.
      drive(1, 2'b01, 16'h80F0, 16'h0000, 1, 0, 8'h00);
      @(negedge clk);
      chk("tmo grant", 32'(req_rdy), 32'b01);
      next_cycle();
      drive(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 8'h00);
      @(negedge clk);
      chk("tmo cmd_vld", 32'(cmd_vld), 32'd1);
      next_cycle();
`ifdef UART_ARB_TIMEOUT_EN
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk($sformatf("tmo wait%0d busy", n), 32'(busy), 32'd1);
         chk($sformatf("tmo wait%0d resp_vld", n), 32'(resp_vld), 32'd0);
         next_cycle();
      end
      @(negedge clk);
      chk("tmo resp_vld", 32'(resp_vld), 32'b01);
      chk("tmo resp_err", 32'(resp_err), 32'd1);
      chk("tmo resp_data", 32'(resp_data), 32'hFF);
      chk("tmo busy", 32'(busy), 32'd0);
      $display("timeout: resp_vld=%b resp_err=%b resp_data=%h", resp_vld, resp_err, resp_data);
      next_cycle();

      // read_rdy arriving in the timeout cycle wins.
      drive(1, 2'b01, 16'h80F1, 16'h0000, 1, 0, 8'h00);
      @(negedge clk);
      chk("race grant", 32'(req_rdy), 32'b01);
      next_cycle();
      drive(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 8'h00);
      next_cycle();
      for (int n = 0; n < 7; n++) next_cycle();
      drive(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 8'h3C);
      @(negedge clk);
      chk("race busy", 32'(busy), 32'd1);
      next_cycle();
      drive(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 8'h00);
      @(negedge clk);
      chk("race resp_vld", 32'(resp_vld), 32'b01);
      chk("race resp_err", 32'(resp_err), 32'd0);
      chk("race resp_data", 32'(resp_data), 32'h3C);
      $display("race: resp_vld=%b resp_err=%b resp_data=%h", resp_vld, resp_err, resp_data);
`else
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         chk($sformatf("notmo wait%0d busy", n), 32'(busy), 32'd1);
         chk($sformatf("notmo wait%0d resp_vld", n), 32'(resp_vld), 32'd0);
         next_cycle();
      end
      drive(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 8'h3C);
      next_cycle();
      drive(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 8'h00);
      @(negedge clk);
      chk("late resp_vld", 32'(resp_vld), 32'b01);
      chk("late resp_data", 32'(resp_data), 32'h3C);
      chk("late resp_err", 32'(resp_err), 32'd0);
      chk("late busy", 32'(busy), 32'd0);
      $display("late read: resp_vld=%b resp_data=%h busy=%b", resp_vld, resp_data, busy);
`endif
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_arb.md
Name: uart_cmd_arb

Overview:
- Round-robin arbiter that shares one uart command port (cmd_in/cmd_vld/cmd_rdy) among NREQ requesters.
- Routes the uart read return (read_rdy/read_data) back to the requester that issued the read command.
- Sits between the uart instance and its client blocks.
- Exactly one command is in flight at a time.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- RD_TIMEOUT, 50000, cycles to wait for read_rdy before aborting; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- req_cmd  in  NREQ*16  per-requester command; slice i is bits [16*i+15:16*i].
- req_vld  in  NREQ  per-requester command valid.
- req_rdy  out  NREQ  one-cycle accept pulse to the granted requester.
- resp_data  out  8  read data returned to a requester.
- resp_vld  out  NREQ  one-cycle pulse to the owner of the read.
- resp_err  out  1  read aborted by timeout; qualified by resp_vld.
- busy  out  1  high in any state other than IDLE.
- cmd_in  out  16  command to the uart.
- cmd_vld  out  1  command valid to the uart.
- cmd_rdy  in  1  uart accepts the command.
- read_rdy  in  1  uart read data valid; single-cycle pulse.
- read_data  in  8  uart read data.

Behaviour:
- Command format: cmd[15] = 1 marks a read, which expects exactly one read_rdy. cmd[15] = 0 is a write/config command with no response. The arbiter does not interpret the other bits.
- Reset, sampled only on the clk edge, sets:
  - state = IDLE, rr_ptr = 0, grant = 0;
  - cmd_in = 0, cmd_vld = 0, req_rdy = 0, resp_vld = 0, resp_data = 0, resp_err = 0, busy = 0.
- Reset asserted mid-operation abandons the in-flight command; cmd_vld is low after that edge. No resp_vld is issued for the abandoned read.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE, in a cycle T where any req_vld is high:
  - Grant the first requester with req_vld high, searching from rr_ptr upward with wrap.
  - Drive req_rdy[g] combinationally high in cycle T; requester g's command transfers at the T edge.
  - Register cmd_in <= req_cmd slice g, set grant <= g, rr_ptr <= (g+1) mod NREQ, go to ISSUE.
  - cmd_vld is high from T+1.
- ISSUE:
  - Hold cmd_vld = 1 and cmd_in stable until cmd_rdy = 1 at a clk edge.
  - On that edge, cmd_vld <= 0. Then go to WAIT_RD if cmd_in[15] = 1, else to IDLE.
  - The next grant is possible in the cycle after the transfer (minimum 2 cycles per write command).
- WAIT_RD:
  - When read_rdy = 1: resp_data <= read_data, resp_vld[grant] <= 1 for one cycle, resp_err <= 0, go to IDLE.
  - IDLE may grant a new request in the same cycle that resp_vld is high.
- read_rdy in IDLE or ISSUE is ignored and produces no resp_vld.
- resp_vld is one-hot or zero. req_rdy is one-hot or zero, and is asserted only in IDLE.
- Requesters must hold req_cmd and req_vld until req_rdy. Deasserting req_vld before grant is legal and withdraws the request.
- Round-robin fairness: with all NREQ requesting continuously, every requester is granted once in each NREQ consecutive grants.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_RD and increments each WAIT_RD cycle.
  - When the counter reaches RD_TIMEOUT-1 without read_rdy: resp_vld[grant] = 1, resp_err = 1, resp_data = 8'hFF, go to IDLE.
  - If read_rdy arrives in the timeout cycle, read_rdy wins and resp_err = 0.
- Undefined:
  - WAIT_RD waits indefinitely.
  - resp_err is tied to 0 and no counter exists.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with req_vld = 2'b11 -> all outputs 0, no req_rdy. Release -> first grant goes to requester 0 (rr_ptr = 0).
- Single write: req_cmd[15:0] = 16'h000A, req_vld[0] pulse, cmd_rdy tied 1 -> req_rdy[0] in cycle T, cmd_vld = 1 with cmd_in = 16'h000A in T+1 only, busy low at T+2, no resp_vld.
- Backpressure: cmd_rdy low for 5 cycles after cmd_vld rises -> cmd_vld and cmd_in held 5 cycles, transfer on 6th edge, no second req_rdy meanwhile.
- Read routing: requester 1 sends 16'h8012. Drive read_rdy for 1 cycle with read_data = 8'h5C, 3 cycles after the transfer -> resp_vld = 2'b10, resp_data = 8'h5C. A spurious read_rdy in IDLE gives no resp_vld.
- Fairness: both requesters hold req_vld with writes, cmd_rdy = 1 -> grants alternate 0,1,0,1 over 8 commands; each req_rdy is one-hot.
- Timeout (macro on, RD_TIMEOUT = 8): read with no read_rdy -> after 8 WAIT_RD cycles, resp_vld[grant] = 1, resp_err = 1, resp_data = 8'hFF, state back to IDLE. Macro off: same stimulus -> busy stays high forever.
